mp_out_serializer: RTL and testbench
====================================

Name: mp_out_serializer

Overview:
- Return path of the SHA-256 UART datapath. Collects the 256-bit digest from the SHA-256 core, one 32-bit word at a time, into an internal buffer.
- Serializes the buffer into bytes for the UART transmitter, one byte per TX handshake, most-significant byte first.
- Mirror of the input message packer. The host receives H0..H7 in big-endian byte order.

Parameters:
- DATA_WIDTH, 32, width of one digest word from the core.
- NUM_WORDS, 8, number of words per digest. NUM_BYTES = NUM_WORDS*DATA_WIDTH/8 = 32.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- core_data_in  input  DATA_WIDTH  digest word from the core. H0 arrives first.
- core_dv_in  input  1  core_data_in valid. Sampled only while ready_out=1.
- ready_out  output  1  block can accept digest words.
- tx_byte_out  output  8  byte presented to the UART transmitter.
- tx_dv_out  output  1  one-cycle pulse; tx_byte_out is valid in that cycle.
- tx_active_in  input  1  UART transmitter busy.
- tx_done_in  input  1  one-cycle pulse when the transmitter finishes a byte.
- done_out  output  1  one-cycle pulse after the last byte's tx_done_in.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to s_IDLE; buffer, word_cnt and byte_cnt clear to 0.
  - tx_byte_out=0, tx_dv_out=0, done_out=0, ready_out=1.
  - Reset asserted mid-transfer aborts the digest. tx_dv_out is 0 from the cycle after rst is sampled. No partial resume.
- ready_out is 1 in s_IDLE and s_COLLECT and 0 in every other state. core_dv_in while ready_out=0 is ignored; no buffer change.
- s_IDLE:
  - On core_dv_in, store the word at buffer[255:224], set word_cnt=1 and go to s_COLLECT.
  - If NUM_WORDS==1, go directly to s_SEND.
- s_COLLECT:
  - Each core_dv_in stores word k at buffer[255-32k -: 32] and increments word_cnt. Words need not be consecutive.
  - The word making word_cnt==NUM_WORDS moves the FSM to s_SEND and clears byte_cnt to 0 on the same edge.
- s_SEND:
  - If tx_active_in=0, register tx_dv_out=1 and tx_byte_out=buffer[255-8*byte_cnt -: 8], then go to s_WAIT.
  - Otherwise hold in s_SEND.
  - First tx_dv_out appears one cycle after entering s_SEND if the transmitter is idle.
- s_WAIT:
  - tx_dv_out returns to 0 after a single cycle.
  - tx_byte_out holds its value until the next load.
  - On tx_done_in: if byte_cnt==NUM_BYTES-1, go to s_DONE; else increment byte_cnt and go to s_SEND.
- s_DONE: done_out=1 for exactly one cycle, then go to s_IDLE with counters cleared.
- Stray tx_done_in in s_IDLE, s_COLLECT or s_SEND is ignored.
- Steady-state throughput: one byte per tx_done_in, plus 1 cycle of load overhead.
- Widths:
  - word_cnt is clog2(NUM_WORDS+1) bits.
  - byte_cnt is clog2(max byte count) bits: 6 bits with the optional feature, 5 without.
  - Counters never wrap; they are bounded by the state transitions.
- Simultaneous events:
  - core_dv_in arriving on the same edge that leaves s_COLLECT is already counted; no extra word is accepted.
  - rst has priority over everything.

Optional Feature:
- Macro: MP_OUT_ASCII_HEX_EN.
- Defined: each digest byte is sent as two ASCII lowercase hex characters, high nibble first. 0-9 map to 0x30-0x39 and a-f map to 0x61-0x66. 64 TX handshakes are made per digest; last byte index is 63. Character k selects nibble buffer[255-4k -: 4].
- Undefined: raw binary, 32 handshakes per digest.

Decomposition:
- Package mp_out_pkg holds:
  - state encoding: s_IDLE, s_COLLECT, s_SEND, s_WAIT, s_DONE;
  - NUM_BYTES_RAW=32 and NUM_BYTES_HEX=64;
  - the counter widths.
- One sub-module, nibble_to_ascii: a combinational 4-bit to 8-bit hex lookup. Instantiated only under MP_OUT_ASCII_HEX_EN.

Test Plan:
- Digest of SHA-256("abc"), ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, fed as 8 consecutive words with an idle TX model:
  - expect 32 tx_dv_out pulses with bytes 0xBA, 0x78, 0x16, 0xBF … 0x15, 0xAD;
  - expect done_out exactly one cycle after the 32nd tx_done_in.
- Same digest with MP_OUT_ASCII_HEX_EN defined:
  - expect 64 bytes, the first four being 0x62, 0x61, 0x37, 0x38 ("ba78");
  - expect the last two to be 0x61, 0x64 ("ad").
- Words fed with gaps of 0-5 cycles, and core_dv_in held high during s_SEND:
  - expect ready_out=0 after the 8th word;
  - expect the extra words dropped and the output identical to the first test.
- tx_active_in held high for 20 cycles on entering s_SEND:
  - expect no tx_dv_out until tx_active_in falls;
  - expect tx_dv_out one cycle after it falls, with byte 0xBA.
- rst asserted for 1 cycle after the 10th tx_done_in:
  - expect tx_dv_out=0, ready_out=1 and state s_IDLE on the next edge;
  - a fresh digest then transmits from byte 0.
- Stray tx_done_in pulses while in s_IDLE and s_COLLECT: expect no state or counter change and no tx_dv_out.

Source files
------------

// File: rtl/mp_out_pkg.sv
// Shared state encoding, byte counts and counter widths for the digest output serializer.
// Build option: MP_OUT_ASCII_HEX_EN selects lowercase ASCII-hex output instead of raw bytes.
package mp_out_pkg;

  typedef enum logic [2:0] {
    s_IDLE    = 3'd0,
    s_COLLECT = 3'd1,
    s_SEND    = 3'd2,
    s_WAIT    = 3'd3,
    s_DONE    = 3'd4
  } state_e;

  localparam int unsigned NUM_BYTES_RAW = 32;
  localparam int unsigned NUM_BYTES_HEX = 64;

`ifdef MP_OUT_ASCII_HEX_EN
  localparam int unsigned CHARS_PER_BYTE = 2;
  localparam int unsigned BYTE_CNT_W     = $clog2(NUM_BYTES_HEX);
`else
  localparam int unsigned CHARS_PER_BYTE = 1;
  localparam int unsigned BYTE_CNT_W     = $clog2(NUM_BYTES_RAW);
`endif

  localparam int unsigned WORD_CNT_W = $clog2(8 + 1);

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit to lowercase ASCII hex character lookup.
module nibble_to_ascii (
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    ascii_o = 8'h30 + {4'h0, nibble_i};
    if (nibble_i > 4'd9) begin
      ascii_o = 8'h57 + {4'h0, nibble_i};
    end
  end

endmodule

// File: rtl/mp_out_serializer.sv
// Collects a SHA-256 digest word by word and replays it to the UART TX, MSB first.
// Build option: MP_OUT_ASCII_HEX_EN sends each byte as two lowercase ASCII hex characters.
module mp_out_serializer
  import mp_out_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] core_data_in,
  input  logic                  core_dv_in,
  output logic                  ready_out,
  output logic [7:0]            tx_byte_out,
  output logic                  tx_dv_out,
  input  logic                  tx_active_in,
  input  logic                  tx_done_in,
  output logic                  done_out
);

  localparam int unsigned BufW     = DATA_WIDTH * NUM_WORDS;
  localparam int unsigned NumXfers = BufW / 8 * CHARS_PER_BYTE;
  localparam int unsigned WordCntW = $clog2(NUM_WORDS + 1);
  localparam int unsigned ByteCntW = $clog2(NumXfers);
  localparam int unsigned IdxW     = $clog2(BufW);

  state_e              state_q;
  logic [BufW-1:0]     buffer_q;
  logic [WordCntW-1:0] word_cnt_q;
  logic [ByteCntW-1:0] byte_cnt_q;
  logic [IdxW-1:0]     word_lsb;
  logic [7:0]          tx_char;

  // Word k lands at the top of the buffer minus k words, so H0 ends up in the MSBs.
  assign word_lsb = IdxW'(BufW - DATA_WIDTH * (word_cnt_q + 1));

`ifdef MP_OUT_ASCII_HEX_EN
  logic [IdxW-1:0] nib_lsb;
  logic [3:0]      nibble;

  assign nib_lsb = IdxW'(BufW - 4 * (byte_cnt_q + 1));
  assign nibble  = buffer_q[nib_lsb +: 4];

  nibble_to_ascii u_nibble_to_ascii (
    .nibble_i (nibble),
    .ascii_o  (tx_char)
  );
`else
  logic [IdxW-1:0] byte_lsb;

  assign byte_lsb = IdxW'(BufW - 8 * (byte_cnt_q + 1));
  assign tx_char  = buffer_q[byte_lsb +: 8];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= s_IDLE;
      buffer_q    <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      tx_byte_out <= '0;
      tx_dv_out   <= 1'b0;
      done_out    <= 1'b0;
      ready_out   <= 1'b1;
    end else begin
      tx_dv_out <= 1'b0;
      done_out  <= 1'b0;
      case (state_q)
        // IDLE and COLLECT share the store path; word_cnt is 0 in IDLE.
        s_IDLE, s_COLLECT: begin
          if (core_dv_in) begin
            buffer_q[word_lsb +: DATA_WIDTH] <= core_data_in;
            word_cnt_q <= word_cnt_q + 1'b1;
            if (word_cnt_q == WordCntW'(NUM_WORDS - 1)) begin
              state_q    <= s_SEND;
              byte_cnt_q <= '0;
              ready_out  <= 1'b0;
            end else begin
              state_q <= s_COLLECT;
            end
          end
        end
        s_SEND: begin
          if (!tx_active_in) begin
            tx_dv_out   <= 1'b1;
            tx_byte_out <= tx_char;
            state_q     <= s_WAIT;
          end
        end
        s_WAIT: begin
          if (tx_done_in) begin
            if (byte_cnt_q == ByteCntW'(NumXfers - 1)) begin
              state_q  <= s_DONE;
              done_out <= 1'b1;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
              state_q    <= s_SEND;
            end
          end
        end
        s_DONE: begin
          state_q    <= s_IDLE;
          word_cnt_q <= '0;
          byte_cnt_q <= '0;
          ready_out  <= 1'b1;
        end
        default: begin
          state_q   <= s_IDLE;
          ready_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_out_serializer.sv
// Scoreboard bench for mp_out_serializer: random digests, TX latency, stray pulses and abort.
module tb_mp_out_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] core_data_in;
  logic        core_dv_in;
  logic        ready_out;
  logic [7:0]  tx_byte_out;
  logic        tx_dv_out;
  logic        done_out;
  logic        tx_active_m = 1'b0;
  logic        hold_busy   = 1'b0;
  logic        tx_done_m   = 1'b0;
  logic        stray_done  = 1'b0;
  logic        tx_active_in;
  logic        tx_done_in;

  assign tx_active_in = tx_active_m | hold_busy;
  assign tx_done_in   = tx_done_m | stray_done;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_done_cyc = -10;
  int          n_done  = 0;
  int          tx_lat  = 0;
  logic [7:0]  exp_q[$];
  int          done_q[$];
  logic [7:0]  mon_exp;
  logic [31:0] words[8];

  mp_out_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .core_data_in (core_data_in),
    .core_dv_in   (core_dv_in),
    .ready_out    (ready_out),
    .tx_byte_out  (tx_byte_out),
    .tx_dv_out    (tx_dv_out),
    .tx_active_in (tx_active_in),
    .tx_done_in   (tx_done_in),
    .done_out     (done_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: digest bytes big-endian from H0, optionally as lowercase hex text.
  function automatic void push_digest();
    logic [7:0] b;
`ifdef MP_OUT_ASCII_HEX_EN
    string s;
`endif
    for (int i = 0; i < 32; i++) begin
      b = 8'(words[i / 4] >> (24 - 8 * (i % 4)));
`ifdef MP_OUT_ASCII_HEX_EN
      s = $sformatf("%02h", b);
      exp_q.push_back(s[0]);
      exp_q.push_back(s[1]);
`else
      exp_q.push_back(b);
`endif
    end
    done_q.push_back(1);
  endfunction

  task automatic load_abc();
    words[0] = 32'hba7816bf; words[1] = 32'h8f01cfea;
    words[2] = 32'h414140de; words[3] = 32'h5dae2223;
    words[4] = 32'hb00361a3; words[5] = 32'h96177a9c;
    words[6] = 32'hb410ff61; words[7] = 32'hf20015ad;
  endtask

  task automatic load_random();
    for (int i = 0; i < 8; i++) words[i] = $urandom;
  endtask

  // Monitor: pops the scoreboard on every byte and every done pulse.
  always @(negedge clk) begin
    if (tx_dv_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_tx_dv", tx_dv_out, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("tx_byte", tx_byte_out, mon_exp);
      end
    end
    if (done_out) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", done_out, 0);
      end else begin
        void'(done_q.pop_front());
        check("done_bytes_left", exp_q.size(), 0);
        check("done_latency", cyc - last_done_cyc, 1);
      end
    end
  end

  // UART TX model: busy for tx_lat cycles after each load, then a one-cycle done pulse.
  initial begin : tx_model
    int busy;
    busy = -1;
    forever begin
      @(negedge clk);
      tx_done_m = 1'b0;
      if (busy > 0) begin
        busy--;
      end else if (busy == 0) begin
        tx_done_m     = 1'b1;
        tx_active_m   = 1'b0;
        last_done_cyc = cyc;
        n_done++;
        busy = -1;
      end else if (tx_dv_out) begin
        tx_active_m = 1'b1;
        busy = tx_lat;
      end
    end
  end

  task automatic feed(input int max_gap, input int hold_extra, input bit stray);
    int g;
    for (int k = 0; k < 8; k++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
        core_dv_in   = 1'b0;
        core_data_in = $urandom;
        @(negedge clk);
      end
      if (stray && k > 0) begin
        core_dv_in = 1'b0;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        check("stray_collect_ready", ready_out, 1);
        check("stray_collect_dv", tx_dv_out, 0);
      end
      core_dv_in   = 1'b1;
      core_data_in = words[k];
      @(negedge clk);
    end
    check("ready_after_last_word", ready_out, 0);
    repeat (hold_extra) begin
      core_dv_in   = 1'b1;
      core_data_in = $urandom;
      @(negedge clk);
    end
    core_dv_in = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (done_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_timeout"}, (done_q.size() == 0), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int base;
    int t;
    rst          = 1'b1;
    core_dv_in   = 1'b0;
    core_data_in = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", ready_out, 1);
    check("reset_tx_dv", tx_dv_out, 0);
    check("reset_done", done_out, 0);
    check("reset_byte", tx_byte_out, 0);
    rst = 1'b0;
    @(negedge clk);

    // Stray done while idle must be ignored.
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    @(negedge clk);
    check("stray_idle_ready", ready_out, 1);
    check("stray_idle_dv", tx_dv_out, 0);

    // Known digest, back-to-back words, fast transmitter.
    load_abc();
    tx_lat = 0;
    push_digest();
    feed(0, 0, 1'b0);
    wait_done("abc");

    // Gapped words, core_dv held after the last word, stray dones during collect.
    load_abc();
    tx_lat = 2;
    push_digest();
    feed(5, 6, 1'b1);
    wait_done("abc_gaps");

    // Transmitter busy for 20 cycles on entering send.
    load_abc();
    tx_lat    = 1;
    hold_busy = 1'b1;
    push_digest();
    feed(0, 0, 1'b0);
    repeat (20) begin
      check("busy_no_dv", tx_dv_out, 0);
      @(negedge clk);
    end
    hold_busy = 1'b0;
    @(negedge clk);
    check("busy_release_dv", tx_dv_out, 1);
`ifdef MP_OUT_ASCII_HEX_EN
    check("busy_release_byte", tx_byte_out, 8'h62);
`else
    check("busy_release_byte", tx_byte_out, 8'hba);
`endif
    wait_done("busy");

    // Random digests with random TX latency.
    for (int r = 0; r < 4; r++) begin
      load_random();
      tx_lat = int'($urandom_range(3, 0));
      push_digest();
      feed(3, (r % 2 == 1) ? int'($urandom_range(6, 1)) : 0, r == 0);
      wait_done("random");
    end

    // Abort with reset after the 10th byte completes.
    load_random();
    tx_lat = 1;
    push_digest();
    feed(2, 0, 1'b0);
    base = n_done;
    t = 0;
    while (n_done < base + 10 && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("rst_wait_timeout", (n_done >= base + 10), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_tx_dv", tx_dv_out, 0);
    check("abort_ready", ready_out, 1);
    check("abort_done", done_out, 0);
    exp_q.delete();
    done_q.delete();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Fresh digest after abort starts again from byte 0.
    load_random();
    tx_lat = 0;
    push_digest();
    feed(1, 0, 1'b0);
    wait_done("after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 500000", $time);
    $fatal(1, "watchdog");
  end

endmodule
